// File: rtl/psum_pkg.sv
// psum_pkg: shared lane geometry, FSM states and saturating lane add for psum_acc
package psum_pkg;
  localparam int LANES = 36;
  localparam int LW = 24;
  localparam int FRAME_W = 864;
  typedef enum logic {IDLE, ACCUM} state_t;
  // Returns {saturated, sum} with the sum clamped to the signed LW-bit range.
  function automatic logic [LW:0] sat_add(input logic signed [LW-1:0] a, input logic signed [LW-1:0] b);
    logic [LW:0] s;
    s = {a[LW-1], a} + {b[LW-1], b};
    return (s[LW] == s[LW-1]) ? {1'b0, s[LW-1:0]} : {1'b1, s[LW], {(LW-1){~s[LW]}}};
  endfunction
endpackage

// File: rtl/psum_acc_if.sv
// psum_acc_if: job config, Psum input stream, output frame handshake and error flags
// master drives cfg_*, Psum_valid, Psum, out_ready; slave (psum_acc) drives busy, out_*, *_err
interface psum_acc_if;
  import psum_pkg::*;
  logic cfg_start;
  logic [3:0] cfg_passes;
  logic cfg_relu;
  logic Psum_valid;
  logic [FRAME_W-1:0] Psum;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [FRAME_W-1:0] out_data;
  logic ovf_err;
  logic sat_err;
  modport master(
    output cfg_start, cfg_passes, cfg_relu, Psum_valid, Psum, out_ready,
    input busy, out_valid, out_data, ovf_err, sat_err
  );
  modport slave(
    input cfg_start, cfg_passes, cfg_relu, Psum_valid, Psum, out_ready,
    output busy, out_valid, out_data, ovf_err, sat_err
  );
endinterface

// File: rtl/psum_fifo.sv
// psum_fifo: DEPTH-entry frame FIFO; push is dropped when full unless a pop frees a slot the same edge
// ports: clk, rst, push/push_data/full (write side), ready/valid/data (head, valid/ready pop)
module psum_fifo import psum_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic pop, put;
  assign valid = cnt != '0;
  assign full = cnt == CW'(DEPTH);
  assign pop = valid & ready;
  assign put = push & (~full | pop);
  assign data = mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (put) begin
        mem[wr] <= push_data;
        wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + 1'b1;
      end
      if (pop) rd <= (rd == AW'(DEPTH - 1)) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(put) - CW'(pop);
    end
  end
endmodule

// File: rtl/psum_acc.sv
// psum_acc: accumulates groups of Psum frames per lane with saturation, optional ReLU, into an output FIFO
// ports: clk, rst (sync, active-high), bus (psum_acc_if.slave: config, Psum stream, output frames, errors)
module psum_acc import psum_pkg::*; #(
  parameter int LANES = psum_pkg::LANES,
  parameter int LW = psum_pkg::LW,
  parameter int FDEPTH = 2
) (
  input logic clk,
  input logic rst,
  psum_acc_if.slave bus
);
  state_t state, state_nxt;
  logic [3:0] cnt, passes;
  logic relu;
  logic [FRAME_W-1:0] acc, sum_frame, push_frame;
  logic [LANES-1:0] sat_lane;
  logic take, last, push, full, pop;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb state_nxt = bus.cfg_start ? ACCUM : state;
  assign bus.busy = state == ACCUM;
  // a restart pulse takes priority over a frame arriving in the same cycle
  assign take = (state == ACCUM) & bus.Psum_valid & ~bus.cfg_start;
  assign last = ({1'b0, cnt} + 5'd1) == {1'b0, passes};
  assign push = take & last;
  assign pop = bus.out_valid & bus.out_ready;
  // first frame of a group loads; later frames saturate-add; ReLU only shapes the pushed copy
  always_comb begin
    sum_frame = '0;
    push_frame = '0;
    sat_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      {sat_lane[k], sum_frame[k*LW +: LW]} = (cnt == '0) ? {1'b0, bus.Psum[k*LW +: LW]} : sat_add(acc[k*LW +: LW], bus.Psum[k*LW +: LW]);
      push_frame[k*LW +: LW] = (relu & sum_frame[k*LW + LW - 1]) ? '0 : sum_frame[k*LW +: LW];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      passes <= '0;
      relu <= 1'b0;
      bus.ovf_err <= 1'b0;
      bus.sat_err <= 1'b0;
    end else if (bus.cfg_start) begin
      acc <= '0;
      cnt <= '0;
      passes <= (bus.cfg_passes == '0) ? 4'd1 : bus.cfg_passes;
      relu <= bus.cfg_relu;
    end else if (take) begin
      acc <= sum_frame;
      cnt <= last ? '0 : cnt + 4'd1;
      bus.sat_err <= bus.sat_err | (|sat_lane);
      bus.ovf_err <= bus.ovf_err | (last & full & ~pop);
    end
  end
  psum_fifo #(.DEPTH(FDEPTH), .W(FRAME_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(push_frame),
    .full(full),
    .ready(bus.out_ready),
    .valid(bus.out_valid),
    .data(bus.out_data)
  );
endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: directed and random stimulus against a lane-integer / frame-queue reference model
module tb_psum_acc;
  import psum_pkg::*;
  localparam int MAXV = 8388607;
  localparam int MINV = -8388608;
  localparam int FD = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  psum_acc_if bus();
  psum_acc #(.LANES(LANES), .LW(LW), .FDEPTH(FD)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_bad = 0;
  int acc_m [LANES];
  int cnt_m = 0;
  int passes_m = 0;
  bit relu_m = 0, busy_m = 0, ovf_m = 0, sat_m = 0;
  logic [FRAME_W-1:0] q [$];

  task automatic check(input string tag, input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] fill(input int v);
    logic [FRAME_W-1:0] f;
    for (int k = 0; k < LANES; k++) f[k*LW +: LW] = LW'(v);
    return f;
  endfunction

  // reference: per-lane integer sums clamped to the lane range, frames kept in a bounded queue
  task automatic model();
    logic [FRAME_W-1:0] f;
    int v, s;
    bit pop;
    if (rst) begin
      busy_m = 0; cnt_m = 0; passes_m = 0; relu_m = 0; ovf_m = 0; sat_m = 0;
      for (int k = 0; k < LANES; k++) acc_m[k] = 0;
      q.delete();
    end else begin
      pop = q.size() > 0 && bus.out_ready;
      if (pop) void'(q.pop_front());
      if (bus.cfg_start) begin
        busy_m = 1;
        cnt_m = 0;
        passes_m = (bus.cfg_passes == 0) ? 1 : int'(bus.cfg_passes);
        relu_m = bus.cfg_relu;
      end else if (busy_m && bus.Psum_valid) begin
        f = '0;
        for (int k = 0; k < LANES; k++) begin
          v = $signed(bus.Psum[k*LW +: LW]);
          if (cnt_m == 0) s = v;
          else begin
            s = acc_m[k] + v;
            if (s > MAXV) begin s = MAXV; sat_m = 1; end
            else if (s < MINV) begin s = MINV; sat_m = 1; end
          end
          acc_m[k] = s;
          f[k*LW +: LW] = (relu_m && s < 0) ? '0 : LW'(s);
        end
        cnt_m++;
        if (cnt_m == passes_m) begin
          cnt_m = 0;
          if (q.size() < FD) q.push_back(f);
          else ovf_m = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit st, input logic [3:0] np, input bit rl, input bit v, input logic [FRAME_W-1:0] p, input bit rdy);
    rst = r;
    bus.cfg_start = st;
    bus.cfg_passes = np;
    bus.cfg_relu = rl;
    bus.Psum_valid = v;
    bus.Psum = p;
    bus.out_ready = rdy;
    model();
    @(posedge clk);
    #1;
    check("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) check("out_data", bus.out_data, q[0]);
    check("busy", bus.busy, busy_m);
    check("ovf_err", bus.ovf_err, ovf_m);
    check("sat_err", bus.sat_err, sat_m);
  endtask

  task automatic reset_dut();
    cyc(1, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic start(input logic [3:0] np, input bit rl, input bit rdy);
    cyc(0, 1, np, rl, 0, '0, rdy);
  endtask
  task automatic frame(input logic [FRAME_W-1:0] p, input bit rdy);
    cyc(0, 0, 0, 0, 1, p, rdy);
  endtask
  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, '0, rdy);
  endtask

  initial begin
    logic [FRAME_W-1:0] rf;
    reset_dut();
    reset_dut();
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    frame(fill(3), 1);
    check("idle_ignores_psum", bus.out_valid, 0);
    start(1, 0, 1);
    frame(fill(5), 1);
    check("p1_valid", bus.out_valid, 1);
    check("p1_data", bus.out_data, fill(5));
    idle(1);
    start(3, 0, 1);
    frame(fill(100), 1);
    frame(fill(-300), 1);
    check("p3_no_early_out", bus.out_valid, 0);
    frame(fill(50), 1);
    check("p3_sum", bus.out_data, fill(-150));
    idle(1);
    start(3, 1, 1);
    frame(fill(100), 1);
    frame(fill(-300), 1);
    frame(fill(50), 1);
    check("p3_relu", bus.out_data, fill(0));
    idle(1);
    start(2, 0, 1);
    frame(fill('h7FFFF0), 1);
    frame(fill('h000100), 1);
    check("sat_data", bus.out_data, fill('h7FFFFF));
    check("sat_flag", bus.sat_err, 1);
    idle(1);
    reset_dut();
    start(1, 0, 0);
    frame(fill(1), 0);
    frame(fill(2), 0);
    frame(fill(3), 0);
    check("ovf_flag", bus.ovf_err, 1);
    check("ovf_head", bus.out_data, fill(1));
    idle(1);
    check("drain_second", bus.out_data, fill(2));
    idle(1);
    check("drain_empty", bus.out_valid, 0);
    reset_dut();
    start(4, 0, 1);
    frame(fill(9), 1);
    frame(fill(9), 1);
    reset_dut();
    start(1, 0, 1);
    frame(fill(7), 1);
    check("rst_mid_data", bus.out_data, fill(7));
    check("rst_mid_errs", {bus.ovf_err, bus.sat_err}, 0);
    idle(1);
    start(0, 0, 0);
    frame(fill(10), 0);
    frame(fill(11), 0);
    frame(fill(12), 1);
    check("poppush_no_ovf", bus.ovf_err, 0);
    check("poppush_head", bus.out_data, fill(11));
    idle(1);
    check("poppush_tail", bus.out_data, fill(12));
    idle(1);
    start(4'($urandom_range(5)), 1'($urandom), 1);
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < LANES; k++)
        rf[k*LW +: LW] = (i % 7 < 2) ? LW'($urandom) : LW'($urandom_range(200) - 100);
      cyc($urandom_range(999) == 0, $urandom_range(39) == 0, 4'($urandom_range(5)), 1'($urandom),
          $urandom_range(9) < 7, rf, $urandom_range(9) < 6);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 Parameter LANES, default 36: number of partial-sum lanes packed in Psum.
REQ-002 Parameter LW, default 24: signed lane width; LANES*LW SHALL equal 864.
REQ-003 Parameter FDEPTH, default 2: output FIFO depth in frames.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 cfg_start  in  1: one-cycle pulse that begins a new accumulation job.
REQ-007 cfg_passes  in  4: Psum frames per output frame; 0 treated as 1; sampled on cfg_start.
REQ-008 cfg_relu  in  1: clamp negative lanes to 0 on output; sampled on cfg_start.
REQ-009 Psum_valid  in  1: one Psum frame present this cycle from the adder stage; no backpressure.
REQ-010 Psum  in  864: LANES packed signed lanes, lane k at bits [k*LW +: LW].
REQ-011 busy  out  1: high in ACCUM.
REQ-012 out_valid  out  1: head of output FIFO valid.
REQ-013 out_ready  in  1: consumer accepts head when out_valid and out_ready are both high.
REQ-014 out_data  out  864: FIFO head frame.
REQ-015 ovf_err  out  1: sticky; frame completed while FIFO full.
REQ-016 sat_err  out  1: sticky; any lane saturated during accumulation.

Function
REQ-017 FSM states: IDLE, ACCUM. IDLE->ACCUM on cfg_start; ACCUM->IDLE on rst only; cfg_start in ACCUM restarts the job: pass count cleared, accumulator discarded.
REQ-018 In IDLE, Psum_valid SHALL be ignored.
REQ-019 In ACCUM, each Psum_valid adds every lane to its accumulator with signed saturation to [-2^(LW-1), 2^(LW-1)-1]; the first frame of a group loads rather than adds.
REQ-020 Pass counter increments per accepted frame; on the frame where count+1 == passes, the finished frame (post-ReLU if enabled) is pushed to the FIFO in the same edge, counter returns to 0, state stays ACCUM.
REQ-021 Latency: finished frame visible on out_data/out_valid the cycle after its last Psum_valid when FIFO was empty.
REQ-022 FIFO full at push: frame dropped, ovf_err set, FIFO contents unchanged.
REQ-023 Pop and push in same cycle with FIFO full: pop first, push succeeds, no ovf_err.
REQ-024 out_data holds stable while out_valid high and out_ready low.
REQ-025 ReLU applies only at push; accumulator retains signed value.
REQ-026 Read/write pointers wrap modulo FDEPTH; occupancy counter range 0..FDEPTH.

Reset
REQ-027 On rst: state IDLE, busy 0, out_valid 0, out_data 0, FIFO empty, counters 0, accumulators 0, ovf_err 0, sat_err 0, latched cfg 0.
REQ-028 rst mid-job discards accumulator and FIFO contents; rst wins over simultaneous cfg_start and Psum_valid.
REQ-029 Sticky errors clear only on rst.

Structure
REQ-030 Package psum_pkg holds LANES, LW, FRAME_W=864, FSM state enumeration, saturating-add function.
REQ-031 One sub-module psum_fifo (FDEPTH x 864, valid/ready pop, push with full flag); lane arithmetic stays in psum_acc.

Verification
REQ-032 passes=1, relu=0, Psum lanes all 5, out_ready=1 -> next cycle out_valid=1, every lane 5.
REQ-033 passes=3, lanes +100,-300,+50 -> one output, lanes -150; relu=1 same input -> lanes 0.
REQ-034 passes=2, lanes 0x7FFFF0 then 0x000100 -> lanes 0x7FFFFF, sat_err=1.
REQ-035 passes=1, out_ready=0, three frames -> FIFO holds first two, ovf_err=1; then out_ready=1 -> exactly two frames drained in order.
REQ-036 passes=4, rst after two frames, then cfg_start passes=1, one frame of 7 -> output lanes 7, no residue, errors 0.
REQ-037 FIFO full, out_ready=1 and final Psum_valid same cycle -> no ovf_err, frame appears after prior entries.
